branch_computation: RTL and testbench

BRANCH_COMPUTATION -- requirements
Module: branch_computation

---
 rtl/branch_computation.sv | 116 +++++++++++
 tb/tb_branch_computation.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/branch_computation.sv
`default_nettype none
// ============================================================================
// Module   : branch_computation
// Brief    : Branch/jump resolution with a combinational branch-target adder
//            and a one-cycle registered redirect (valid/taken/target/misaligned).
// Revision : 1.0
// ============================================================================
module branch_computation #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] nextInstr,
    input  logic [XLEN-1:0] signExtOffset,
    output logic [XLEN-1:0] branchAddress,
    input  logic            valid_in,
    input  logic [2:0]      br_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic [25:0]     jump_index,
    input  logic            flush,
    output logic            valid_q,
    output logic            taken_q,
    output logic [XLEN-1:0] target_q,
    output logic            misaligned_q
);

    localparam logic [2:0] c_OP_NONE = 3'b000;
    localparam logic [2:0] c_OP_BEQ  = 3'b001;
    localparam logic [2:0] c_OP_BNE  = 3'b010;
    localparam logic [2:0] c_OP_BLEZ = 3'b011;
    localparam logic [2:0] c_OP_BGTZ = 3'b100;
    localparam logic [2:0] c_OP_BLTZ = 3'b101;
    localparam logic [2:0] c_OP_BGEZ = 3'b110;
    localparam logic [2:0] c_OP_J    = 3'b111;

    logic            w_rsZero;
    logic            w_rsNeg;
    logic            w_equal;
    logic            w_taken;
    logic [XLEN-1:0] w_jumpTarget;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic            w_accept;

    logic            r_valid;
    logic            r_taken;
    logic [XLEN-1:0] r_target;
    logic            r_misaligned;

    // Word offset scaled to bytes; overflow wraps silently.
    assign branchAddress = nextInstr + {signExtOffset[XLEN-3:0], 2'b00};

    assign w_jumpTarget  = {nextInstr[XLEN-1:28], jump_index, 2'b00};

    assign w_rsZero = (rs_val == '0);
    assign w_rsNeg  = rs_val[XLEN-1];
    assign w_equal  = (rs_val == rt_val);

    always_comb begin
        w_taken = 1'b0;
        case (br_op)
            c_OP_NONE: w_taken = 1'b0;
            c_OP_BEQ:  w_taken = w_equal;
            c_OP_BNE:  w_taken = !w_equal;
            c_OP_BLEZ: w_taken = w_rsNeg || w_rsZero;
            c_OP_BGTZ: w_taken = !w_rsNeg && !w_rsZero;
            c_OP_BLTZ: w_taken = w_rsNeg;
            c_OP_BGEZ: w_taken = !w_rsNeg;
            c_OP_J:    w_taken = 1'b1;
            default:   w_taken = 1'b0;
        endcase
    end

    // Not-taken requests redirect to the sequential address so target_q is
    // always the correct next fetch address.
    always_comb begin
        w_target = nextInstr;
        if (w_taken) begin
            if (br_op == c_OP_J) begin
                w_target = w_jumpTarget;
            end else begin
                w_target = branchAddress;
            end
        end
    end

    assign w_misaligned = w_taken && (br_op != c_OP_J) && (w_target[1:0] != 2'b00);
    assign w_accept     = valid_in && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
            r_misaligned <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_taken      <= w_taken;
            r_target     <= w_target;
            r_misaligned <= w_misaligned;
        end else begin
            // Idle or flushed: drop the request but keep the last redirect.
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_misaligned <= 1'b0;
        end
    end

    assign valid_q      = r_valid;
    assign taken_q      = r_taken;
    assign target_q     = r_target;
    assign misaligned_q = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_branch_computation.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_computation
// Brief    : Directed scoreboard bench for branch_computation.
// Revision : 1.0
// ============================================================================
module tb_branch_computation;

    logic        clk;
    logic        reset;
    logic [31:0] nextInstr;
    logic [31:0] signExtOffset;
    logic [31:0] branchAddress;
    logic        valid_in;
    logic [2:0]  br_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [25:0] jump_index;
    logic        flush;
    logic        valid_q;
    logic        taken_q;
    logic [31:0] target_q;
    logic        misaligned_q;

    typedef struct {
        string       name;
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    branch_computation #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .nextInstr    (nextInstr),
        .signExtOffset(signExtOffset),
        .branchAddress(branchAddress),
        .valid_in     (valid_in),
        .br_op        (br_op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .jump_index   (jump_index),
        .flush        (flush),
        .valid_q      (valid_q),
        .taken_q      (taken_q),
        .target_q     (target_q),
        .misaligned_q (misaligned_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge produces one registered response, compared at negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (valid_q !== e.valid || taken_q !== e.taken ||
                target_q !== e.target || misaligned_q !== e.mis) begin
                bad++;
                $display("FAIL %s: got v=%b t=%b tgt=%h mis=%b, want v=%b t=%b tgt=%h mis=%b",
                         e.name, valid_q, taken_q, target_q, misaligned_q,
                         e.valid, e.taken, e.target, e.mis);
            end
        end
    end

    task automatic checkAddr(input string name, input logic [31:0] want);
        #1;
        total++;
        if (branchAddress !== want) begin
            bad++;
            $display("FAIL %s: branchAddress got %h want %h", name, branchAddress, want);
        end
    endtask

    task automatic issue(input string name, input logic rst, input logic vin,
                         input logic fl, input logic [2:0] op,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ni, input logic [31:0] off,
                         input logic [25:0] ji,
                         input logic ev, input logic et,
                         input logic [31:0] etgt, input logic em);
        exp_t e;
        reset = rst; valid_in = vin; flush = fl; br_op = op;
        rs_val = rs; rt_val = rt; nextInstr = ni; signExtOffset = off; jump_index = ji;
        @(posedge clk);
        #1;
        e.name = name; e.valid = ev; e.taken = et; e.target = etgt; e.mis = em;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; br_op = 3'b000;
        rs_val = '0; rt_val = '0; jump_index = '0;

        // Combinational adder with no clock edges involved.
        nextInstr = 32'd100;  signExtOffset = 32'd512;       checkAddr("addr_100_512", 32'd2148);
        nextInstr = 32'd0;    signExtOffset = 32'd0;         checkAddr("addr_zero", 32'd0);
        nextInstr = 32'h10;   signExtOffset = 32'hFFFFFFFF;  checkAddr("addr_backward", 32'h0C);
        nextInstr = 32'hFFFFFFF0; signExtOffset = 32'h8;     checkAddr("addr_wrap", 32'h10);

        //     name          rst vin fl op      rs            rt            ni            off           ji          v  t  target        mis
        issue("reset_init",  1, 1, 0, 3'b001, 32'd5,        32'd5,        32'h400,      32'hFFFFFFFC, 26'h0,      0, 0, 32'h0,        0);
        issue("beq_taken",   0, 1, 0, 3'b001, 32'd5,        32'd5,        32'h400,      32'hFFFFFFFC, 26'h0,      1, 1, 32'h3F0,      0);
        issue("bne_equal",   0, 1, 0, 3'b010, 32'd7,        32'd7,        32'h200,      32'h10,       26'h0,      1, 0, 32'h200,      0);
        issue("bltz_min",    0, 1, 0, 3'b101, 32'h80000000, 32'h0,        32'h100,      32'h4,        26'h0,      1, 1, 32'h110,      0);
        issue("bgez_min",    0, 1, 0, 3'b110, 32'h80000000, 32'h0,        32'h100,      32'h4,        26'h0,      1, 0, 32'h100,      0);
        issue("blez_min",    0, 1, 0, 3'b011, 32'h80000000, 32'h0,        32'h100,      32'h4,        26'h0,      1, 1, 32'h110,      0);
        issue("bgtz_min",    0, 1, 0, 3'b100, 32'h80000000, 32'h0,        32'h100,      32'h4,        26'h0,      1, 0, 32'h100,      0);
        issue("jump",        0, 1, 0, 3'b111, 32'h0,        32'h0,        32'hA0000004, 32'h3,        26'h0000010,1, 1, 32'hA0000040, 0);
        issue("idle_hold",   0, 0, 0, 3'b001, 32'h1,        32'h1,        32'h800,      32'h1,        26'h0,      0, 0, 32'hA0000040, 0);
        issue("flush_drop",  0, 1, 1, 3'b001, 32'h1,        32'h1,        32'h800,      32'h1,        26'h0,      0, 0, 32'hA0000040, 0);
        issue("misaligned",  0, 1, 0, 3'b001, 32'h1,        32'h1,        32'h202,      32'h1,        26'h0,      1, 1, 32'h206,      1);
        issue("op_none",     0, 1, 0, 3'b000, 32'h1,        32'h1,        32'h300,      32'h5,        26'h0,      1, 0, 32'h300,      0);
        issue("bgtz_pos",    0, 1, 0, 3'b100, 32'h1,        32'h0,        32'h1000,     32'h2,        26'h0,      1, 1, 32'h1008,     0);
        issue("blez_zero",   0, 1, 0, 3'b011, 32'h0,        32'h0,        32'h20,       32'hFFFFFFFE, 26'h0,      1, 1, 32'h18,       0);
        issue("bne_diff",    0, 1, 0, 3'b010, 32'h3,        32'hFFFFFFFD, 32'h40,       32'h1,        26'h0,      1, 1, 32'h44,       0);
        issue("untaken_odd", 0, 1, 0, 3'b001, 32'h1,        32'h2,        32'h203,      32'h1,        26'h0,      1, 0, 32'h203,      0);

        // Mid-stream reset with a taken request present; adder must still track.
        reset = 1'b1; valid_in = 1'b1; flush = 1'b0; br_op = 3'b001;
        rs_val = 32'h9; rt_val = 32'h9; nextInstr = 32'h1000; signExtOffset = 32'h10;
        checkAddr("addr_in_reset", 32'h1040);
        issue("reset_mid",   1, 1, 0, 3'b001, 32'h9,        32'h9,        32'h1000,     32'h10,       26'h0,      0, 0, 32'h0,        0);
        issue("bgez_zero",   0, 1, 0, 3'b110, 32'h0,        32'h0,        32'h50,       32'h3,        26'h0,      1, 1, 32'h5C,       0);
        issue("idle_hold2",  0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h60,       32'h0,        26'h0,      0, 0, 32'h5C,       0);

        valid_in = 1'b0;
        begin
            int budget;
            budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL drain: %0d responses left, want 0", sb.size());
            end
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
